instr_queue: RTL

Front-end fetch stage that sits directly upstream of the decoder and reorder buffer.
- Generates sequential fetch PCs and requests 32-bit instructions from the instruction cache.
- Buffers returned instructions in a circular FIFO.
- Issues one instruction per cycle to the decoder while the ROB reports space.
- On a ROB exception (mispredict/redirect), flushes all buffered and in-flight work and restarts fetch at the ROB-supplied PC.

---
 rtl/instr_queue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/instr_queue.sv
// instr_queue: fetch front end between the instruction cache and the decoder.
// It generates sequential fetch PCs, buffers the returned words in a circular
// FIFO, and issues one word per cycle while the ROB has room. A ROB exception
// flushes everything and restarts fetch at the redirect PC.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no request outstanding; request next word when room exists
//   S_WAIT    | request outstanding; returned word is enqueued
//   S_DISCARD | request outstanding but flushed; returned word is dropped
module instr_queue #(
  parameter int          QueueLength   = 16,
  parameter int          PointerLength = 3,
  parameter logic [31:0] ResetPc       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_ready_from_rob,
  input  logic        is_exception_from_rob,
  input  logic [31:0] pc_from_rob,
  input  logic        is_valid_from_ic,
  input  logic [31:0] instr_from_ic,
  output logic        is_fetch_to_ic,
  output logic [31:0] pc_to_ic,
  output logic        is_empty_to_dc,
  output logic [31:0] instr_to_dc,
  output logic [31:0] pc_to_dc
);

  localparam int CountWidth = PointerLength + 2;

  typedef logic [PointerLength:0] ptr_t;
  typedef logic [CountWidth-1:0]  cnt_t;

  localparam cnt_t CountMax = cnt_t'(QueueLength);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t state_n;

  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;
  logic [31:0] fetch_pc;

  logic [31:0] instr_storage [QueueLength];
  logic [31:0] pc_storage    [QueueLength];

  logic        flush;
  logic        full;
  logic        empty;
  logic        enq;
  logic        issue;
  logic        fetch_n;
  logic [31:0] pc_to_ic_n;

  assign flush = is_exception_from_rob;
  assign full  = (count == CountMax);
  assign empty = (count == '0);

  // A flush blocks issue; the head entry is about to be discarded anyway.
  assign issue = !empty && is_ready_from_rob && !flush;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Fetch FSM next state, request outputs and enqueue decision.
  // Room is checked only when a request is launched (no request is ever
  // outstanding in S_IDLE), so a returning word can always be written.
  always_comb begin
    state_n    = state;
    fetch_n    = is_fetch_to_ic;
    pc_to_ic_n = pc_to_ic;
    enq        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!flush && !full) begin
          fetch_n    = 1'b1;
          pc_to_ic_n = fetch_pc;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (is_valid_from_ic) begin
          fetch_n = 1'b0;
          enq     = !flush;
          state_n = S_IDLE;
        end else if (flush) begin
          state_n = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The request stays up with its old address until the cache answers;
        // that answer completes the handshake and is thrown away.
        if (is_valid_from_ic) begin
          fetch_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: begin
        fetch_n = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Registered cache request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_fetch_to_ic <= 1'b0;
      pc_to_ic       <= 32'h0000_0000;
    end else begin
      is_fetch_to_ic <= fetch_n;
      pc_to_ic       <= pc_to_ic_n;
    end
  end

  // Next fetch address: redirect on flush, otherwise advance per accepted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= ResetPc;
    end else if (flush) begin
      fetch_pc <= pc_from_rob;
    end else if (enq) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; enqueue and issue together leave count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + ptr_t'(1);
      end
      if (issue) begin
        head <= head + ptr_t'(1);
      end
      unique case ({enq, issue})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_storage[tail] <= instr_from_ic;
      pc_storage[tail]    <= pc_to_ic;
    end
  end

  // Decoder outputs: registered from the head; data holds when nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_empty_to_dc <= 1'b1;
      instr_to_dc    <= 32'h0000_0000;
      pc_to_dc       <= 32'h0000_0000;
    end else if (issue) begin
      is_empty_to_dc <= 1'b0;
      instr_to_dc    <= instr_storage[head];
      pc_to_dc       <= pc_storage[head];
    end else begin
      is_empty_to_dc <= 1'b1;
    end
  end

endmodule
